// File: rtl/imem_boot_loader.sv
// Boot loader: assembles a byte stream into 32-bit words, writes instruction memory, then releases the CPU.
// Optional trailing XOR checksum byte is enabled with `define IMEM_BOOT_LOADER_CHECKSUM_EN.
module imem_boot_loader #(
    parameter int unsigned MEM_DEPTH = 256,
    parameter int unsigned ADDR_W    = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_req_i,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_data_i,
    output logic              byte_ready_o,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [31:0]       imem_wdata_o,
    output logic              cpu_rst_o,
    output logic              cpu_start_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [15:0]       word_cnt_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR0,
        S_HDR1,
        S_DATA,
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
        S_CSUM,
`endif
        S_DONE,
        S_ERR
    } state_e;

    state_e            state_q;
    logic [7:0]        n_lo_q;
    logic [15:0]       n_q;
    logic [23:0]       asm_q;
    logic [1:0]        bcnt_q;
    logic [15:0]       word_cnt_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              ready_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic              cpu_rst_q;
    logic              cpu_start_q;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
    logic [7:0]        xor_q;
`endif

    logic        accept;
    logic [15:0] hdr_n;
    logic        last_word;

    assign accept    = byte_valid_i & ready_q;
    assign hdr_n     = {byte_data_i, n_lo_q};
    assign last_word = ((word_cnt_q + 16'd1) == n_q);

    // State machine with every output registered alongside the state transition.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= S_IDLE;
            n_lo_q      <= 8'd0;
            n_q         <= 16'd0;
            asm_q       <= 24'd0;
            bcnt_q      <= 2'd0;
            word_cnt_q  <= 16'd0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= 32'd0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cpu_rst_q   <= 1'b0;
            cpu_start_q <= 1'b0;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
            xor_q       <= 8'd0;
`endif
        end else begin
            we_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE, S_ERR: begin
                    if (load_req_i) begin
                        state_q     <= S_HDR0;
                        ready_q     <= 1'b1;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        err_q       <= 1'b0;
                        word_cnt_q  <= 16'd0;
                        bcnt_q      <= 2'd0;
                        cpu_rst_q   <= 1'b0;
                        cpu_start_q <= 1'b0;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
                        xor_q       <= 8'd0;
`endif
                    end
                end
                S_HDR0: begin
                    if (accept) begin
                        n_lo_q  <= byte_data_i;
                        state_q <= S_HDR1;
                    end
                end
                S_HDR1: begin
                    if (accept) begin
                        n_q <= hdr_n;
                        if (17'(hdr_n) > 17'(MEM_DEPTH)) begin
                            state_q <= S_ERR;
                            ready_q <= 1'b0;
                            busy_q  <= 1'b0;
                            err_q   <= 1'b1;
                        end else if (hdr_n == 16'd0) begin
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
                            state_q     <= S_CSUM;
`else
                            state_q     <= S_DONE;
                            ready_q     <= 1'b0;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                            cpu_rst_q   <= 1'b1;
                            cpu_start_q <= 1'b1;
`endif
                        end else begin
                            state_q <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        bcnt_q <= bcnt_q + 2'd1;
                        asm_q  <= {byte_data_i, asm_q[23:8]};
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
                        xor_q  <= xor_q ^ byte_data_i;
`endif
                        if (bcnt_q == 2'd3) begin
                            we_q       <= 1'b1;
                            addr_q     <= ADDR_W'(word_cnt_q);
                            wdata_q    <= {byte_data_i, asm_q};
                            word_cnt_q <= word_cnt_q + 16'd1;
                            if (last_word) begin
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
                                state_q     <= S_CSUM;
`else
                                state_q     <= S_DONE;
                                ready_q     <= 1'b0;
                                busy_q      <= 1'b0;
                                done_q      <= 1'b1;
                                cpu_rst_q   <= 1'b1;
                                cpu_start_q <= 1'b1;
`endif
                            end
                        end
                    end
                end
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
                S_CSUM: begin
                    if (accept) begin
                        ready_q <= 1'b0;
                        busy_q  <= 1'b0;
                        if (byte_data_i == xor_q) begin
                            state_q     <= S_DONE;
                            done_q      <= 1'b1;
                            cpu_rst_q   <= 1'b1;
                            cpu_start_q <= 1'b1;
                        end else begin
                            state_q <= S_ERR;
                            err_q   <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign byte_ready_o = ready_q;
    assign imem_we_o    = we_q;
    assign imem_addr_o  = addr_q;
    assign imem_wdata_o = wdata_q;
    assign cpu_rst_o    = cpu_rst_q;
    assign cpu_start_o  = cpu_start_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign word_cnt_o   = word_cnt_q;

endmodule
